// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: widths, opcode constants, and the fetch stage's state and entry types.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ILEN_BYTES = 4;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop and flush. DEPTH must be a power of two.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries below count_q are ever presented.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited requests, buffers in-order responses.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched / perf_dropped counters.
module fetch_unit #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    import riscv_pkg::fetch_entry_t;
    import riscv_pkg::fetch_state_e;
    import riscv_pkg::ST_RUN;
    import riscv_pkg::ST_DRAIN;
    import riscv_pkg::ILEN_BYTES;

    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     CREDITS = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(ILEN_BYTES - 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    fetch_state_e    state_q, state_d;

    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   count;
    logic            req_fire;
    logic            rsp_discard;
    logic            rsp_push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign redirect_target = redirect_pc & ALIGN;
    assign imem_req_addr   = pc_q & ALIGN;

    // Buffered entries hold credits too, so a response always finds a free slot.
    assign imem_req_valid = !rst && !redirect_valid
                          && (({1'b0, inflight_q} + {1'b0, count}) < CREDITS);
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_discard = imem_rsp_valid && ((drop_q != '0) || redirect_valid);
    assign rsp_push    = imem_rsp_valid && !rsp_discard;
    assign push_data   = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign if_valid = !rst && !fifo_empty;
    assign pop      = if_valid && if_ready;
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;

        case ({req_fire, imem_rsp_valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if (req_fire) pc_d = pc_q + STEP;
        if (rsp_push) rsp_pc_d = rsp_pc_q + STEP;
        if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;

        // Every request still outstanding after this cycle belongs to the old path.
        if (redirect_valid) begin
            pc_d     = redirect_target;
            rsp_pc_d = redirect_target;
            drop_d   = inflight_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drop_d != '0) state_d = ST_DRAIN;
            ST_DRAIN: if (drop_d == '0) state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            state_q    <= ST_RUN;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
        end
    end

    no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        !(rsp_push && fifo_full && !pop && !redirect_valid));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] dropped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (pop && !redirect_valid && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
            if (rsp_discard && (dropped_q != '1))           dropped_q <= dropped_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for streaming/backpressure plus redirect/reset cases.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          hold  = 1'b0;
    logic [31:0] pend_addr [$];
    int          pend_cyc  [$];

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t vec [18];

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] ra, logic iv,
                                logic [31:0] ipc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.ra = ra; v.iv = iv; v.ipc = ipc;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[24:0], 7'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_rsp();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!hold && pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Called at the negedge: record any accepted request, advance to the next cycle's inputs.
    task automatic end_cycle();
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        redirect_valid = 1'b0;
        drive_rsp();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            mid();
            end_cycle();
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        hold           = 1'b0;
        pend_addr.delete();
        pend_cyc.delete();
        imem_rsp_valid = 1'b0;
        mid();
        chk("rst_cycle_req_valid", imem_req_valid, 0);
        chk("rst_cycle_if_valid", if_valid, 0);
        end_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;

        // Cycle-by-cycle expectations from reset with latency-1 memory, DEPTH=2 credits.
        vec[0]  = mk(1, 1, 32'h00, 0, 32'h00);
        vec[1]  = mk(1, 1, 32'h04, 0, 32'h00);
        vec[2]  = mk(1, 0, 32'h00, 1, 32'h00);
        vec[3]  = mk(1, 1, 32'h08, 1, 32'h04);
        vec[4]  = mk(1, 1, 32'h0C, 0, 32'h00);
        vec[5]  = mk(1, 0, 32'h00, 1, 32'h08);
        vec[6]  = mk(1, 1, 32'h10, 1, 32'h0C);
        vec[7]  = mk(1, 1, 32'h14, 0, 32'h00);
        vec[8]  = mk(0, 0, 32'h00, 1, 32'h10);
        vec[9]  = mk(0, 0, 32'h00, 1, 32'h10);
        vec[10] = mk(0, 0, 32'h00, 1, 32'h10);
        vec[11] = mk(0, 0, 32'h00, 1, 32'h10);
        vec[12] = mk(0, 0, 32'h00, 1, 32'h10);
        vec[13] = mk(1, 0, 32'h00, 1, 32'h10);
        vec[14] = mk(1, 1, 32'h18, 1, 32'h14);
        vec[15] = mk(1, 1, 32'h1C, 0, 32'h00);
        vec[16] = mk(1, 0, 32'h00, 1, 32'h18);
        vec[17] = mk(1, 1, 32'h20, 1, 32'h1C);

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 18; i++) begin
            if_ready = vec[i].rdy;
            mid();
            chk($sformatf("tbl%0d_req_valid", i + 1), imem_req_valid, vec[i].rv);
            if (vec[i].rv) chk($sformatf("tbl%0d_req_addr", i + 1), imem_req_addr, vec[i].ra);
            chk($sformatf("tbl%0d_if_valid", i + 1), if_valid, vec[i].iv);
            if (vec[i].iv) begin
                chk($sformatf("tbl%0d_if_pc", i + 1), if_pc, vec[i].ipc);
                chk($sformatf("tbl%0d_if_instr", i + 1), if_instr, mem_word(vec[i].ipc));
            end
            end_cycle();
        end

        // Redirect with two requests outstanding: both responses dropped.
        do_reset();
        hold     = 1'b1;
        if_ready = 1'b1;
        mid(); chk("a_c1_addr", imem_req_addr, 32'h0); end_cycle();
        mid(); chk("a_c2_addr", imem_req_addr, 32'h4); end_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        mid(); chk("a_redir_req_valid", imem_req_valid, 0);
        hold = 1'b0;
        end_cycle();
        mid(); chk("a_c4_req_valid", imem_req_valid, 0); chk("a_c4_if_valid", if_valid, 0);
        end_cycle();
        mid(); chk("a_c5_req_valid", imem_req_valid, 1); chk("a_c5_addr", imem_req_addr, 32'h100);
        chk("a_c5_if_valid", if_valid, 0);
        end_cycle();
        mid(); chk("a_c6_addr", imem_req_addr, 32'h104); chk("a_c6_if_valid", if_valid, 0);
        end_cycle();
        mid(); chk("a_c7_if_valid", if_valid, 1); chk("a_c7_if_pc", if_pc, 32'h100);
        chk("a_c7_if_instr", if_instr, mem_word(32'h100));
`ifdef FETCH_PERF_CNT_EN
        chk("a_perf_dropped", perf_dropped, 2);
`endif
        end_cycle();

        // Redirect coinciding with a response and a pop; target misaligned.
        do_reset();
        if_ready = 1'b1;
        idle(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        mid(); chk("b_redir_req_valid", imem_req_valid, 0); chk("b_redir_if_pc", if_pc, 32'h8);
        chk("b_redir_rsp_present", imem_rsp_valid, 1);
        end_cycle();
        mid(); chk("b_c7_if_valid", if_valid, 0); chk("b_c7_addr", imem_req_addr, 32'h200);
        chk("b_c7_req_valid", imem_req_valid, 1);
        end_cycle();
        mid(); chk("b_c8_if_valid", if_valid, 0); chk("b_c8_addr", imem_req_addr, 32'h204);
        end_cycle();
        mid(); chk("b_c9_if_valid", if_valid, 1); chk("b_c9_if_pc", if_pc, 32'h200);
        chk("b_c9_if_instr", if_instr, mem_word(32'h200));
`ifdef FETCH_PERF_CNT_EN
        chk("b_perf_dropped", perf_dropped, 1);
`endif
        end_cycle();

        // PC wraps past the top of the address space.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        mid(); chk("c_redir_req_valid", imem_req_valid, 0); end_cycle();
        mid(); chk("c_top_addr", imem_req_addr, 32'hFFFF_FFFC); end_cycle();
        mid(); chk("c_wrap_addr", imem_req_addr, 32'h0); chk("c_wrap_valid", imem_req_valid, 1);
        end_cycle();
        mid(); chk("c_top_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("c_top_if_instr", if_instr, mem_word(32'hFFFF_FFFC));
        end_cycle();

        // Reset with the buffer full.
        do_reset();
        if_ready = 1'b0;
        idle(3);
        mid(); chk("d_full_if_valid", if_valid, 1); chk("d_full_req_valid", imem_req_valid, 0);
        end_cycle();
        do_reset();
        mid(); chk("d_post_if_valid", if_valid, 0); chk("d_post_req_valid", imem_req_valid, 1);
        chk("d_post_addr", imem_req_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("d_perf_fetched_clr", perf_fetched, 0);
        chk("d_perf_dropped_clr", perf_dropped, 0);
`endif
        // Reset while a stale response is pending: the drop count must clear.
        hold = 1'b1;
        end_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        mid(); end_cycle();
        mid(); chk("d_redir_addr", imem_req_addr, 32'h40); end_cycle();
        if_ready = 1'b1;
        do_reset();
        mid(); chk("d2_post_addr", imem_req_addr, 32'h0); chk("d2_post_if_valid", if_valid, 0);
        end_cycle();
        mid(); chk("d2_c2_if_valid", if_valid, 0); end_cycle();
        mid(); chk("d2_c3_if_valid", if_valid, 1); chk("d2_c3_if_pc", if_pc, 32'h0);
        chk("d2_c3_if_instr", if_instr, 32'h0050_0093);
        end_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
